// File: rtl/decode_queue_unit.sv
// rtl/decode_queue_unit.sv - queued RV32IM decoder with registered controls and divide hold-off
module decode_queue_unit #(
    parameter int QUEUE_DEPTH  = 4,
    parameter int DIV_LATENCY  = 4,
    parameter bit ENABLE_RV32M = 1'b1,
    parameter bit ENABLE_CSR   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [5:0]  alu_select,
    output logic        reg_write_en,
    output logic [2:0]  data_mem_write,
    output logic [3:0]  data_mem_read,
    output logic [3:0]  branch_ctrl,
    output logic [2:0]  immediate_select,
    output logic        operand1_select,
    output logic        operand2_select,
    output logic [1:0]  writeback_value_select,
    output logic [3:0]  csr_value_select,
    output logic        illegal_instr,
    output logic        div_busy
);

    localparam int PW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PW + 1;
    localparam int CW    = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_DIV_WAIT = 1'b1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SFMT   = 7'b0101111;
    localparam logic [6:0] OP_IFMT   = 7'b0111111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0]      instr_mem [QUEUE_DEPTH];
    logic [31:0]      pc_mem    [QUEUE_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;

    logic [0:0]       state;
    logic [CW-1:0]    counter;
    logic             out_div;

    logic             push;
    logic             load;
    logic             div_hs;

    assign in_ready = (count < CNT_W'(QUEUE_DEPTH));
    assign push     = in_valid & in_ready & ~flush;
    assign div_hs   = out_valid & out_ready & out_div;
    assign load     = (~out_valid | out_ready) & (count != '0) & (state == ST_RUN) & ~div_hs & ~flush;
    assign div_busy = (state == ST_DIV_WAIT);

    // Storage carries no reset; emptiness is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instruction;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    logic [31:0] head;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic        is_opimm, is_op, is_sfmt, is_ifmt, is_system;
    logic        opcode_ok, rv32m, d_illegal, d_div;
    logic [5:0]  d_alu;
    logic        d_rwe;
    logic [2:0]  d_dmw;
    logic [3:0]  d_dmr;
    logic [3:0]  d_bc;
    logic [2:0]  d_imm;
    logic        d_op1, d_op2;
    logic [1:0]  d_wb;
    logic [3:0]  d_csr;

    assign head   = instr_mem[rd_ptr];
    assign opcode = head[6:0];
    assign f3     = head[14:12];
    assign f7     = head[31:25];

    always_comb begin
        is_lui    = (opcode == OP_LUI);
        is_auipc  = (opcode == OP_AUIPC);
        is_jal    = (opcode == OP_JAL);
        is_jalr   = (opcode == OP_JALR);
        is_branch = (opcode == OP_BRANCH);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_opimm  = (opcode == OP_IMM);
        is_op     = (opcode == OP_REG);
        is_sfmt   = (opcode == OP_SFMT);
        is_ifmt   = (opcode == OP_IFMT);
        is_system = (opcode == OP_SYSTEM);

        opcode_ok = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                    is_opimm | is_op | is_sfmt | is_ifmt | (is_system & ENABLE_CSR);
        rv32m     = is_op & (f7 == 7'b0000001);
        d_illegal = ~opcode_ok | (rv32m & ~ENABLE_RV32M);
        d_div     = rv32m & f3[2] & ~d_illegal & (DIV_LATENCY > 1);

        d_alu[5]   = 1'b0;
        d_alu[4]   = (is_op & (f7 == 7'b0100000) & ((f3 == 3'b000) | (f3 == 3'b101))) |
                     (is_opimm & (f7 == 7'b0100000) & (f3 == 3'b101)) | is_lui;
        d_alu[3]   = rv32m | is_lui;
        d_alu[2:0] = (is_auipc | is_jal | is_load | is_store | is_branch) ? 3'b000 : f3;

        d_rwe = ~(is_store | is_branch | d_illegal);
        d_dmw = {is_store & ~d_illegal, f3[1:0]};
        d_dmr = {is_load & ~d_illegal, f3};
        d_bc  = {(is_jal | is_jalr | is_branch) & ~d_illegal, (is_jal | is_jalr) ? 3'b010 : f3};

        if (is_jal)                                               d_imm = 3'b001;
        else if (is_jalr | is_load | is_opimm | is_system | is_ifmt) d_imm = 3'b010;
        else if (is_branch)                                       d_imm = 3'b011;
        else if (is_store | is_sfmt)                              d_imm = 3'b100;
        else                                                      d_imm = 3'b000;

        d_op1 = is_auipc | is_jal | is_branch;
        d_op2 = is_load | is_opimm | is_auipc | is_store | is_lui | is_jalr | is_jal | is_branch;

        if (is_jal | is_jalr) d_wb = 2'b00;
        else if (is_load)     d_wb = 2'b01;
        else                  d_wb = 2'b10;

        d_csr = {is_system, f3};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid              <= 1'b0;
            out_instruction        <= '0;
            out_pc                 <= '0;
            alu_select             <= '0;
            reg_write_en           <= 1'b0;
            data_mem_write         <= '0;
            data_mem_read          <= '0;
            branch_ctrl            <= '0;
            immediate_select       <= '0;
            operand1_select        <= 1'b0;
            operand2_select        <= 1'b0;
            writeback_value_select <= '0;
            csr_value_select       <= '0;
            illegal_instr          <= 1'b0;
            out_div                <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_div   <= 1'b0;
        end else if (load) begin
            out_valid              <= 1'b1;
            out_instruction        <= head;
            out_pc                 <= pc_mem[rd_ptr];
            alu_select             <= d_alu;
            reg_write_en           <= d_rwe;
            data_mem_write         <= d_dmw;
            data_mem_read          <= d_dmr;
            branch_ctrl            <= d_bc;
            immediate_select       <= d_imm;
            operand1_select        <= d_op1;
            operand2_select        <= d_op2;
            writeback_value_select <= d_wb;
            csr_value_select       <= d_csr;
            illegal_instr          <= d_illegal;
            out_div                <= d_div;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_div   <= 1'b0;
        end
    end

    // The counter starts at DIV_LATENCY-1 and the wait ends on the edge where it reads 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            counter <= '0;
        end else if (flush) begin
            state   <= ST_RUN;
            counter <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (div_hs) begin
                        state   <= ST_DIV_WAIT;
                        counter <= CW'(DIV_LATENCY - 1);
                    end
                end
                default: begin
                    counter <= counter - 1'b1;
                    if (counter == CW'(1)) state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_queue_unit.sv
// tb/tb_decode_queue_unit.sv - directed scoreboard bench for decode_queue_unit
module tb_decode_queue_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instruction = '0;
    logic [31:0] in_pc = '0;

    logic        in_ready, out_valid, reg_write_en, operand1_select, operand2_select, illegal_instr, div_busy;
    logic [31:0] out_instruction, out_pc;
    logic [5:0]  alu_select;
    logic [2:0]  data_mem_write, immediate_select;
    logic [3:0]  data_mem_read, branch_ctrl, csr_value_select;
    logic [1:0]  writeback_value_select;

    logic        n_in_ready, n_out_valid, n_reg_write_en, n_operand1_select, n_operand2_select, n_illegal_instr, n_div_busy;
    logic [31:0] n_out_instruction, n_out_pc;
    logic [5:0]  n_alu_select;
    logic [2:0]  n_data_mem_write, n_immediate_select;
    logic [3:0]  n_data_mem_read, n_branch_ctrl, n_csr_value_select;
    logic [1:0]  n_writeback_value_select;

    decode_queue_unit dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction), .out_pc(out_pc),
        .alu_select(alu_select), .reg_write_en(reg_write_en), .data_mem_write(data_mem_write),
        .data_mem_read(data_mem_read), .branch_ctrl(branch_ctrl), .immediate_select(immediate_select),
        .operand1_select(operand1_select), .operand2_select(operand2_select),
        .writeback_value_select(writeback_value_select), .csr_value_select(csr_value_select),
        .illegal_instr(illegal_instr), .div_busy(div_busy)
    );

    decode_queue_unit #(.ENABLE_CSR(1'b0)) dut_nocsr (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_instruction(n_out_instruction), .out_pc(n_out_pc),
        .alu_select(n_alu_select), .reg_write_en(n_reg_write_en), .data_mem_write(n_data_mem_write),
        .data_mem_read(n_data_mem_read), .branch_ctrl(n_branch_ctrl), .immediate_select(n_immediate_select),
        .operand1_select(n_operand1_select), .operand2_select(n_operand2_select),
        .writeback_value_select(n_writeback_value_select), .csr_value_select(n_csr_value_select),
        .illegal_instr(n_illegal_instr), .div_busy(n_div_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [29:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   n_out  = 0;

    logic [29:0] ctrl_obs;
    assign ctrl_obs = {alu_select, reg_write_en, data_mem_write, data_mem_read, branch_ctrl,
                       immediate_select, operand1_select, operand2_select, writeback_value_select,
                       csr_value_select, illegal_instr};

    // Reference decode for the default-parameter unit, field order as in ctrl_obs.
    function automatic logic [29:0] model(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] alu;
        logic       rwe, op1, op2, ill;
        logic [2:0] dmw, imm;
        logic [3:0] dmr, bc, csr;
        logic [1:0] wb;
        f3  = i[14:12];
        f7  = i[31:25];
        alu = {3'b000, f3};
        rwe = 1'b1; op1 = 1'b0; op2 = 1'b0; ill = 1'b0;
        dmw = {1'b0, f3[1:0]}; dmr = {1'b0, f3}; bc = {1'b0, f3}; csr = {1'b0, f3};
        imm = 3'b000; wb = 2'b10;
        case (i[6:0])
            7'b0110111: begin alu[4] = 1'b1; alu[3] = 1'b1; op2 = 1'b1; end
            7'b0010111: begin alu[2:0] = 3'b000; op1 = 1'b1; op2 = 1'b1; end
            7'b1101111: begin alu[2:0] = 3'b000; bc = 4'b1010; imm = 3'b001; op1 = 1'b1; op2 = 1'b1; wb = 2'b00; end
            7'b1100111: begin bc = 4'b1010; imm = 3'b010; op2 = 1'b1; wb = 2'b00; end
            7'b1100011: begin alu[2:0] = 3'b000; bc[3] = 1'b1; imm = 3'b011; op1 = 1'b1; op2 = 1'b1; rwe = 1'b0; end
            7'b0000011: begin alu[2:0] = 3'b000; dmr[3] = 1'b1; imm = 3'b010; op2 = 1'b1; wb = 2'b01; end
            7'b0100011: begin alu[2:0] = 3'b000; dmw[2] = 1'b1; imm = 3'b100; op2 = 1'b1; rwe = 1'b0; end
            7'b0010011: begin imm = 3'b010; op2 = 1'b1; if (f3 == 3'b101 && f7 == 7'b0100000) alu[4] = 1'b1; end
            7'b0110011: begin
                if (f7 == 7'b0000001) alu[3] = 1'b1;
                if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) alu[4] = 1'b1;
            end
            7'b0101111: imm = 3'b100;
            7'b0111111: imm = 3'b010;
            7'b1110011: begin imm = 3'b010; csr[3] = 1'b1; end
            default:    begin ill = 1'b1; rwe = 1'b0; end
        endcase
        return {alu, rwe, dmw, dmr, bc, imm, op1, op2, wb, csr, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_output_sb_depth", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("out_instruction", out_instruction, e.instr);
            chk("out_pc", out_pc, e.pc);
            chk("decoded_ctrl", {2'b00, ctrl_obs}, {2'b00, e.ctrl});
            n_out = n_out + 1;
        end
    endtask

    // Called at a falling edge with inputs already set for the next rising edge.
    task automatic cycle();
        exp_t e;
        if (!flush && in_valid && in_ready) begin
            e.instr = in_instruction;
            e.pc    = in_pc;
            e.ctrl  = model(in_instruction);
            sb.push_back(e);
        end
        if (out_valid && out_ready) compare_pop();
        @(negedge clk);
        if (flush) sb.delete();
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_pc          = pc;
    endtask

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] DIV  = 32'h0220_C1B3;
    localparam logic [31:0] ADD  = 32'h0020_81B3;
    localparam logic [31:0] CSRW = 32'h3052_9073;
    localparam logic [31:0] BAD  = 32'h0000_007F;

    logic [31:0] t3 [6];
    bit          pushed;
    int          n0;

    initial begin
        t3 = '{32'h1234_50B7, 32'h0000_1117, 32'h0080_00EF, 32'h0020_8463, 32'h0040_A183, 32'h0030_A223};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_div_busy", div_busy, 0);
        chk("rst_illegal", illegal_instr, 0);
        chk("rst_ctrl", {2'b00, ctrl_obs}, 0);
        chk("rst_out_instruction", out_instruction, 0);
        chk("rst_out_pc", out_pc, 0);
        reset = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        drive(ADDI, 32'h100);
        cycle();
        in_valid = 1'b0;
        chk("addi_not_yet_valid", out_valid, 0);
        cycle();
        chk("addi_valid", out_valid, 1);
        chk("addi_alu", alu_select, 6'b000000);
        chk("addi_imm_sel", immediate_select, 3'b010);
        chk("addi_op2", operand2_select, 1);
        chk("addi_rwe", reg_write_en, 1);
        chk("addi_wb", writeback_value_select, 2'b10);
        cycle();
        chk("addi_drained", out_valid, 0);

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(t3[k], 32'h200 + 32'(4 * k));
            cycle();
        end
        drive(t3[5], 32'h214);
        chk("full_in_ready", in_ready, 0);
        chk("full_held_instr", out_instruction, t3[0]);
        chk("full_sb_depth", 32'(sb.size()), 5);
        n0 = n_out;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("stream_valid", out_valid, 1);
            pushed = in_valid && in_ready;
            cycle();
            if (pushed) in_valid = 1'b0;
        end
        chk("stream_count", 32'(n_out - n0), 6);
        chk("stream_done", out_valid, 0);

        drive(DIV, 32'h300);
        cycle();
        drive(ADD, 32'h304);
        cycle();
        in_valid = 1'b0;
        chk("div_valid", out_valid, 1);
        chk("div_alu", alu_select, 6'b001100);
        chk("div_busy_before", div_busy, 0);
        cycle();
        for (int c = 0; c < 3; c++) begin
            chk("div_busy_hold", div_busy, 1);
            chk("div_hold_no_out", out_valid, 0);
            cycle();
        end
        chk("div_busy_end", div_busy, 0);
        chk("div_end_no_out_yet", out_valid, 0);
        cycle();
        chk("add_after_div_valid", out_valid, 1);
        chk("add_after_div_instr", out_instruction, ADD);
        cycle();

        drive(DIV, 32'h400);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        drive(ADDI, 32'h404);
        cycle();
        drive(ADD, 32'h408);
        cycle();
        chk("flush_pre_busy", div_busy, 1);
        chk("flush_pre_sb_depth", 32'(sb.size()), 2);
        flush = 1'b1;
        drive(32'h0010_0113, 32'h40C);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_div_busy", div_busy, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (3) cycle();
        chk("flush_queue_empty", out_valid, 0);

        drive(BAD, 32'h500);
        cycle();
        drive(CSRW, 32'h504);
        cycle();
        in_valid = 1'b0;
        chk("bad_illegal", illegal_instr, 1);
        chk("bad_rwe", reg_write_en, 0);
        cycle();
        chk("csr_legal", illegal_instr, 0);
        chk("csr_value_sel", csr_value_select, 4'b1001);
        chk("nocsr_instr", n_out_instruction, CSRW);
        chk("nocsr_illegal", n_illegal_instr, 1);
        chk("nocsr_rwe", n_reg_write_en, 0);
        cycle();

        drive(DIV, 32'h600);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) chk("rst_mid_busy_before", div_busy, 1);
            drive(ADDI + 32'(k << 20), 32'h604 + 32'(4 * k));
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("rst_mid_valid_before", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_div_busy", div_busy, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("rst_mid_no_reemit", out_valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
